// File: rtl/shot_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shot_arbiter_pkg : shared state encoding, shooter ids, arbitration   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package shot_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    FLIGHT = 2'd2,
    COOL   = 2'd3
  } state_e;

  localparam logic SEL_GREEN = 1'b0;
  localparam logic SEL_RED   = 1'b1;

  localparam int AMMO_W = 4;
  localparam int CNT_W  = 32;

  // On contention the tank that was not served last wins.
  function automatic logic pick_shooter(input logic elig_g, input logic elig_r,
                                        input logic last_sel);
    if (elig_g && elig_r) begin
      return ~last_sel;
    end
    return elig_r ? SEL_RED : SEL_GREEN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shot_ammo_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shot_ammo_ctr : per-tank round counter, load on reload, sat. at zero |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module shot_ammo_ctr
  import shot_arbiter_pkg::*;
#(
  parameter logic [AMMO_W-1:0] AMMO_MAX = 4'd8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              dec_i,
  output logic [AMMO_W-1:0] count_o
);

  logic [AMMO_W-1:0] count_q;
  logic [AMMO_W-1:0] count_d;

  // Reload has priority over a coincident decrement.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = AMMO_MAX;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= AMMO_MAX;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/shot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shot_arbiter : two-tank shot arbiter, launch/flight/cooldown FSM.     |
// | SHOT_AMMO_LIMIT_EN enables per-tank ammo gating.  Rev 1.0            |
// +----------------------------------------------------------------------+
module shot_arbiter
  import shot_arbiter_pkg::*;
#(
  parameter logic [31:0] COOLDOWN   = 32'd2000000,
  parameter logic [31:0] FLIGHT_MAX = 32'd60000000,
  parameter logic [3:0]  AMMO_MAX   = 4'd8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fire_g,
  input  logic       fire_r,
  input  logic       reload_g,
  input  logic       reload_r,
  input  logic       eng_done,
  output logic       eng_start,
  output logic       eng_sel,
  output logic       eng_abort,
  output logic       grant_g,
  output logic       grant_r,
  output logic [3:0] ammo_g,
  output logic [3:0] ammo_r,
  output logic       busy
);

  // A zero count would never match after the post-entry increment, so clamp to one cycle.
  localparam logic [CNT_W-1:0] COOL_LAST   = (COOLDOWN == 32'd0)   ? 32'd0 : COOLDOWN - 32'd1;
  localparam logic [CNT_W-1:0] FLIGHT_LAST = (FLIGHT_MAX == 32'd0) ? 32'd0 : FLIGHT_MAX - 32'd1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_sel_q;
  logic             eng_sel_q;
  logic             eng_start_q;
  logic             eng_abort_q;
  logic             grant_g_q;
  logic             grant_r_q;
  logic             busy_q;

  logic             w_elig_g;
  logic             w_elig_r;
  logic             w_win;

`ifdef SHOT_AMMO_LIMIT_EN
  logic w_dec_g;
  logic w_dec_r;

  // The round is spent at the end of the LAUNCH cycle.
  assign w_dec_g = (state_q == LAUNCH) && (eng_sel_q == SEL_GREEN);
  assign w_dec_r = (state_q == LAUNCH) && (eng_sel_q == SEL_RED);

  shot_ammo_ctr #(.AMMO_MAX(AMMO_MAX)) u_ammo_g (
    .clk     (clock),
    .rst     (reset),
    .load_i  (reload_g),
    .dec_i   (w_dec_g),
    .count_o (ammo_g)
  );

  shot_ammo_ctr #(.AMMO_MAX(AMMO_MAX)) u_ammo_r (
    .clk     (clock),
    .rst     (reset),
    .load_i  (reload_r),
    .dec_i   (w_dec_r),
    .count_o (ammo_r)
  );

  assign w_elig_g = fire_g && (ammo_g != '0);
  assign w_elig_r = fire_r && (ammo_r != '0);
`else
  logic w_unused_reload;

  assign w_unused_reload = reload_g ^ reload_r;
  assign ammo_g   = AMMO_MAX;
  assign ammo_r   = AMMO_MAX;
  assign w_elig_g = fire_g;
  assign w_elig_r = fire_r;
`endif

  assign w_win = pick_shooter(w_elig_g, w_elig_r, last_sel_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_sel_q  <= SEL_RED;
      eng_sel_q   <= SEL_GREEN;
      eng_start_q <= 1'b0;
      eng_abort_q <= 1'b0;
      grant_g_q   <= 1'b0;
      grant_r_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      eng_abort_q <= 1'b0;
      grant_g_q   <= 1'b0;
      grant_r_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_elig_g || w_elig_r) begin
            state_q     <= LAUNCH;
            cnt_q       <= '0;
            eng_sel_q   <= w_win;
            last_sel_q  <= w_win;
            grant_g_q   <= (w_win == SEL_GREEN);
            grant_r_q   <= (w_win == SEL_RED);
            eng_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        LAUNCH: begin
          state_q <= FLIGHT;
          cnt_q   <= '0;
        end
        FLIGHT: begin
          if (eng_done) begin
            state_q <= COOL;
            cnt_q   <= '0;
          end else if (cnt_q == FLIGHT_LAST) begin
            state_q     <= COOL;
            cnt_q       <= '0;
            eng_abort_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        COOL: begin
          if (cnt_q == COOL_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign eng_start = eng_start_q;
  assign eng_abort = eng_abort_q;
  assign eng_sel   = eng_sel_q;
  assign grant_g   = grant_g_q;
  assign grant_r   = grant_r_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_shot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shot_arbiter : timeline model plus directed shots for shot_arbiter|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_shot_arbiter;

  localparam int CD = 5;
  localparam int FM = 100;
  localparam int AM = 8;
`ifdef SHOT_AMMO_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, fire_g, fire_r, reload_g, reload_r, eng_done;
  logic       eng_start, eng_sel, eng_abort, grant_g, grant_r, busy;
  logic [3:0] ammo_g, ammo_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shot_arbiter #(
    .COOLDOWN   (32'd5),
    .FLIGHT_MAX (32'd100),
    .AMMO_MAX   (4'd8)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .fire_g    (fire_g),
    .fire_r    (fire_r),
    .reload_g  (reload_g),
    .reload_r  (reload_r),
    .eng_done  (eng_done),
    .eng_start (eng_start),
    .eng_sel   (eng_sel),
    .eng_abort (eng_abort),
    .grant_g   (grant_g),
    .grant_r   (grant_r),
    .ammo_g    (ammo_g),
    .ammo_r    (ammo_r),
    .busy      (busy)
  );

  // Timeline model: a shot granted at edge L launches in the cycle after L,
  // flies from edge L+2, times out at edge L+1+FM, and cooling ends CD edges later.
  longint ecnt = 0;
  bit     m_valid = 1'b0;
  bit     m_active = 1'b0;
  longint m_t_idle = 0;
  longint m_t_launch = 0;
  bit     m_last = 1'b1;
  bit     m_sel = 1'b0;
  int     m_ammo_g = AM;
  int     m_ammo_r = AM;
  bit     e_start, e_abort, e_gg, e_gr, e_busy;

  always @(posedge clk) begin : p_model
    bit eg, er, win, dec_g, dec_r;
    e_start = 1'b0; e_abort = 1'b0; e_gg = 1'b0; e_gr = 1'b0;
    if (reset === 1'b1) begin
      m_active = 1'b0; m_t_idle = ecnt + 1; m_last = 1'b1; m_sel = 1'b0;
      m_ammo_g = AM; m_ammo_r = AM; e_busy = 1'b0;
    end else begin
      dec_g = m_active && (ecnt == m_t_launch + 1) && !m_sel;
      dec_r = m_active && (ecnt == m_t_launch + 1) && m_sel;
      eg = fire_g && (!LIMIT || m_ammo_g > 0);
      er = fire_r && (!LIMIT || m_ammo_r > 0);
      if (!m_active && ecnt >= m_t_idle && (eg || er)) begin
        win = (eg && er) ? !m_last : er;
        m_active = 1'b1; m_t_launch = ecnt; m_sel = win; m_last = win;
        e_start = 1'b1; e_gg = !win; e_gr = win;
      end else if (m_active && ecnt >= m_t_launch + 2) begin
        if (eng_done || ecnt == m_t_launch + 1 + FM) begin
          e_abort  = !eng_done;
          m_active = 1'b0;
          m_t_idle = ecnt + ((CD == 0) ? 1 : CD) + 1;
        end
      end
      if (LIMIT) begin
        if (reload_g) m_ammo_g = AM; else if (dec_g && m_ammo_g > 0) m_ammo_g--;
        if (reload_r) m_ammo_r = AM; else if (dec_r && m_ammo_r > 0) m_ammo_r--;
      end
      e_busy = m_active || (ecnt + 1 < m_t_idle);
    end
    ecnt++;
    m_valid = 1'b1;
  end

  task automatic check_model();
    logic [13:0] got, exp;
    got = {eng_start, eng_abort, grant_g, grant_r, busy, eng_sel, ammo_g, ammo_r};
    exp = {e_start, e_abort, e_gg, e_gr, e_busy, m_sel, 4'(m_ammo_g), 4'(m_ammo_r)};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL model cyc=%0d {start,abort,gg,gr,busy,sel,ammo_g,ammo_r} got=%b exp=%b",
               ecnt, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_valid) check_model();
  endtask

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, actual, expected);
    end
  endtask

  task automatic wait_start(input int budget);
    int k = 0;
    while (eng_start !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (eng_start !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_start got=no_start exp=start within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int n, nb, g;
    reset = 1'b1; fire_g = 1'b0; fire_r = 1'b0;
    reload_g = 1'b0; reload_r = 1'b0; eng_done = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_ammo_g", ammo_g, 8);
    check("rst_ammo_r", ammo_r, 8);
    check("rst_sel", eng_sel, 0);
    check("rst_start", eng_start, 0);
    reset = 1'b0;
    tick();

    // Single green shot from idle.
    fire_g = 1'b1;
    tick();
    check("t1_grant_g", grant_g, 1);
    check("t1_grant_r", grant_r, 0);
    check("t1_start", eng_start, 1);
    check("t1_sel", eng_sel, 0);
    fire_g = 1'b0;
    tick();
    check("t1_ammo_g", ammo_g, LIMIT ? 7 : 8);
    repeat (3) tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    repeat (8) tick();

    // Both tanks held: alternation from reset.
    do_reset();
    fire_g = 1'b1; fire_r = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_start(30);
      check($sformatf("t2_sel_shot%0d", s), eng_sel, (s == 1) ? 1 : 0);
      repeat (10) tick();
      eng_done = 1'b1; tick(); eng_done = 1'b0;
    end
    fire_g = 1'b0; fire_r = 1'b0;
    repeat (8) tick();

    // Timeout abort; a done during LAUNCH is ignored.
    do_reset();
    fire_r = 1'b1;
    wait_start(20);
    fire_r = 1'b0;
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    n = 1;
    while (eng_abort !== 1'b1 && n < 200) begin tick(); n++; end
    check("t3_abort_latency", n, FM + 1);
    check("t3_busy_in_cool", busy, 1);
    tick();
    check("t3_abort_one_cycle", eng_abort, 0);
    repeat (6) tick();

    // Done on the timeout cycle wins over abort.
    fire_g = 1'b1;
    wait_start(20);
    fire_g = 1'b0;
    repeat (FM) tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    check("t4_no_abort", eng_abort, 0);
    check("t4_busy", busy, 1);
    tick();
    check("t4_no_abort_late", eng_abort, 0);
    repeat (6) tick();

    // Cooldown length with red held.
    fire_r = 1'b1;
    wait_start(20);
    repeat (3) tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    nb = 0; n = 0;
    while (grant_r !== 1'b1 && n < 50) begin
      if (busy === 1'b1) nb++;
      tick();
      n++;
    end
    check("t5_cool_cycles", nb, CD);
    check("t5_grant_latency", n, CD + 1);
    fire_r = 1'b0;
    repeat (3) tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    repeat (8) tick();

    // Reset in the middle of a flight.
    fire_g = 1'b1;
    wait_start(20);
    fire_g = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("t6_busy", busy, 0);
    check("t6_abort", eng_abort, 0);
    check("t6_ammo_g", ammo_g, 8);
    check("t6_grant_g", grant_g, 0);
    reset = 1'b0;
    tick();

`ifdef SHOT_AMMO_LIMIT_EN
    // Exhaust green, then reload.
    do_reset();
    fire_g = 1'b1;
    for (int s = 0; s < 8; s++) begin
      wait_start(30);
      tick();
      eng_done = 1'b1; tick(); eng_done = 1'b0;
    end
    g = 0;
    repeat (15) begin tick(); if (grant_g === 1'b1) g++; end
    check("t7_ammo_empty", ammo_g, 0);
    check("t7_no_grant", g, 0);
    reload_g = 1'b1; tick(); reload_g = 1'b0;
    check("t7_reloaded", ammo_g, 8);
    wait_start(10);
    check("t7_grant_after_reload", grant_g, 1);
    reload_g = 1'b1; tick(); reload_g = 1'b0;
    check("t7_reload_beats_dec", ammo_g, 8);
    fire_g = 1'b0;
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    repeat (8) tick();
`else
    // Unlimited fire: reloads ignored, a ninth shot is still granted.
    do_reset();
    fire_g = 1'b1;
    for (int s = 0; s < 9; s++) begin
      wait_start(30);
      reload_g = 1'b1; tick(); reload_g = 1'b0;
      eng_done = 1'b1; tick(); eng_done = 1'b0;
    end
    check("t7_ninth_granted", eng_sel, 0);
    check("t7_ammo_fixed", ammo_g, 8);
    fire_g = 1'b0;
    repeat (8) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shot_arbiter.md
SHOT_ARBITER -- requirements
Module: shot_arbiter

Interface
REQ-001 SHALL have parameter COOLDOWN, default 32'd2000000, meaning cycles from shot end to next launch.
REQ-002 SHALL have parameter FLIGHT_MAX, default 32'd60000000, meaning maximum cycles a shot may stay in flight before abort.
REQ-003 SHALL have parameter AMMO_MAX, default 4'd8, meaning rounds per tank after reset or reload.
REQ-004 SHALL have ports: clock input 1 system clock; reset input 1 synchronous active-high reset.
REQ-005 SHALL have ports: fire_g input 1 green tank fire request (level); fire_r input 1 red tank fire request (level).
REQ-006 SHALL have ports: reload_g input 1 green reload pulse; reload_r input 1 red reload pulse.
REQ-007 SHALL have ports: eng_done input 1 bullet engine reports stop (wall, base or tank hit).
REQ-008 SHALL have ports: eng_start output 1 one-cycle launch pulse to bullet engine; eng_sel output 1 shooter, 0 green, 1 red.
REQ-009 SHALL have ports: eng_abort output 1 one-cycle forced-stop pulse; grant_g output 1; grant_r output 1 one-cycle grant acknowledges.
REQ-010 SHALL have ports: ammo_g output 4 green rounds left; ammo_r output 4 red rounds left; busy output 1 high when state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, LAUNCH, FLIGHT, COOL.
REQ-012 In IDLE, an eligible request SHALL select a shooter and move to LAUNCH next cycle; eligible means fire asserted, with ammo > 0 when ammo limiting is on.
REQ-013 If both requests are eligible, the winner SHALL be the tank not served last; last_sel SHALL reset to red, so green wins first.
REQ-014 On the IDLE->LAUNCH edge, the registered outputs SHALL assert grant_x and latch eng_sel, so grant_x and eng_sel are valid in the LAUNCH cycle.
REQ-015 eng_sel SHALL hold until the next IDLE->LAUNCH transition.
REQ-016 In LAUNCH, eng_start SHALL be 1 for exactly that cycle; the winner's ammo SHALL decrement by 1; the FSM SHALL go to FLIGHT.
REQ-017 eng_done SHALL be ignored in LAUNCH.
REQ-018 In FLIGHT, eng_done=1 SHALL move the FSM to COOL.
REQ-019 In FLIGHT, if the flight counter reaches FLIGHT_MAX-1 without eng_done, eng_abort SHALL pulse 1 cycle and the FSM SHALL move to COOL.
REQ-020 If eng_done and timeout occur in the same cycle, done SHALL win and eng_abort SHALL stay 0.
REQ-021 COOL SHALL last exactly COOLDOWN cycles, then return to IDLE; COOLDOWN=0 SHALL be treated as 1.
REQ-022 Requests arriving outside IDLE SHALL NOT be queued; a level still held on return to IDLE SHALL be re-arbitrated.
REQ-023 A reload_x pulse SHALL set ammo_x to AMMO_MAX in any state.
REQ-024 If reload and decrement of the same tank coincide, reload SHALL win.
REQ-025 Ammo SHALL saturate at 0 and never wrap.
REQ-026 Counters SHALL be 32-bit, unsigned, and reset to 0 on every state entry.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While reset=1: state IDLE; eng_start, eng_abort, grant_g, grant_r, busy, eng_sel = 0; ammo_g = ammo_r = AMMO_MAX; counters 0; last_sel = red.
REQ-029 Reset asserted mid-FLIGHT SHALL NOT emit eng_abort; the engine receives reset separately.

Configuration
REQ-030 Macro SHOT_AMMO_LIMIT_EN defined SHALL enable ammo tracking and eligibility gating per REQ-012, REQ-016, REQ-023 to REQ-025.
REQ-031 Macro undefined SHALL give unlimited fire: ammo_g and ammo_r tied to AMMO_MAX, reload inputs ignored, eligibility = fire_x only.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=2'd0, LAUNCH=2'd1, FLIGHT=2'd2, COOL=2'd3) and the shooter constants SEL_GREEN=1'b0, SEL_RED=1'b1.
REQ-033 One sub-module, shot_ammo_ctr, SHALL be instantiated per tank: 4-bit counter with load-on-reload, decrement and saturate-at-0.

Verification
REQ-034 Bench SHALL check: fire_g=1 held from idle -> grant_g at cycle 1, eng_start at cycle 1, eng_sel=0, ammo_g 8->7.
REQ-035 Bench SHALL check: fire_g=fire_r=1 across three shots, eng_done 10 cycles after each start -> shooters green, red, green.
REQ-036 Bench SHALL check: no eng_done, FLIGHT_MAX=100 -> eng_abort pulse 100 cycles after FLIGHT entry, then COOL.
REQ-037 Bench SHALL check: macro on, green fires 8 times -> ammo_g=0, the 9th request gets no grant; reload_g pulse -> ammo_g=8, next fire granted.
REQ-038 Bench SHALL check: reset pulse mid-FLIGHT -> next cycle IDLE, busy=0, eng_abort=0, ammo=8.
REQ-039 Bench SHALL check: COOLDOWN=5, fire_r held -> exactly 5 COOL cycles between eng_done and the next grant_r.
